// File: rtl/hazard_ctrl.sv
// ID/EX hazard and sequencing controller: load-use stalls, redirect flush shadow,
// multi-cycle EX handshake with timeout, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic        id_ex_reg_valid_i,
  input  logic [4:0]  id_ex_reg_rd_i,
  input  logic        id_ex_reg_mem_rd_i,
  input  logic        ex_jump_i,
  input  logic        ex_mc_req_i,
  input  logic        mc_done_i,
  output logic        hz_pc_hold_o,
  output logic        hz_if_id_hold_o,
  output logic        hz_if_id_flush_o,
  output logic        hz_id_ex_hold_o,
  output logic        hz_id_ex_flush_o,
  output logic        hz_mc_start_o,
  output logic        hz_mc_err_o,
  output logic [1:0]  hz_state_o,
  output logic [15:0] hz_stall_cnt_o
);
  typedef enum logic [1:0] {RUN = 2'b00, MC_WAIT = 2'b01, FLUSH = 2'b10} state_t;

  localparam logic [15:0] TMO_LAST  = 16'(MC_TIMEOUT - 1);
  localparam logic [3:0]  FLUSH_LD  = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  fcnt, fcnt_n;
  logic [15:0] tcnt, tcnt_n;
  logic [15:0] stall_cnt;
  logic        load_use;

  assign load_use = id_valid_i & id_ex_reg_valid_i & id_ex_reg_mem_rd_i &
                    (id_ex_reg_rd_i != 5'd0) &
                    ((id_rs1_used_i & (id_rs1_i == id_ex_reg_rd_i)) |
                     (id_rs2_used_i & (id_rs2_i == id_ex_reg_rd_i)));

  always_comb begin
    state_n          = state;
    fcnt_n           = fcnt;
    tcnt_n           = tcnt;
    hz_pc_hold_o     = 1'b0;
    hz_if_id_hold_o  = 1'b0;
    hz_if_id_flush_o = 1'b0;
    hz_id_ex_hold_o  = 1'b0;
    hz_id_ex_flush_o = 1'b0;
    hz_mc_start_o    = 1'b0;
    hz_mc_err_o      = 1'b0;
    if (!rst) begin
      case (state)
        MC_WAIT: begin
          // done has priority over a coincident timeout
          if (mc_done_i) begin
            state_n = RUN;
          end else if (tcnt == TMO_LAST) begin
            hz_mc_err_o = 1'b1;
            state_n     = RUN;
          end else begin
            hz_pc_hold_o    = 1'b1;
            hz_if_id_hold_o = 1'b1;
            hz_id_ex_hold_o = 1'b1;
            tcnt_n          = tcnt + 16'd1;
          end
        end
        FLUSH: begin
          hz_if_id_flush_o = 1'b1;
          hz_id_ex_flush_o = 1'b1;
          if (fcnt <= 4'd1) begin
            fcnt_n  = 4'd0;
            state_n = RUN;
          end else begin
            fcnt_n = fcnt - 4'd1;
          end
        end
        default: begin
          if (ex_jump_i && id_ex_reg_valid_i) begin
            hz_if_id_flush_o = 1'b1;
            hz_id_ex_flush_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              fcnt_n  = FLUSH_LD;
              state_n = FLUSH;
            end
          end else if (ex_mc_req_i && id_ex_reg_valid_i) begin
            hz_mc_start_o   = 1'b1;
            hz_pc_hold_o    = 1'b1;
            hz_if_id_hold_o = 1'b1;
            hz_id_ex_hold_o = 1'b1;
            tcnt_n          = 16'd0;
            state_n         = MC_WAIT;
          end else if (load_use) begin
            hz_pc_hold_o     = 1'b1;
            hz_if_id_hold_o  = 1'b1;
            hz_id_ex_flush_o = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      fcnt      <= 4'd0;
      tcnt      <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
      tcnt  <= tcnt_n;
      if (hz_pc_hold_o && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign hz_state_o     = rst ? 2'b00 : state;
  assign hz_stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: main instance (FLUSH_CYCLES=3, MC_TIMEOUT=8) and a
// second instance (FLUSH_CYCLES=1, MC_TIMEOUT=65535) for single-cycle redirect and saturation.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       id_valid, rs1_used, rs2_used, ex_valid, mem_rd, jump, mc_req, mc_done;
  logic [4:0] rs1, rs2, rd;
  logic       pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, mc_start, mc_err;
  logic [1:0] state;
  logic [15:0] stall;
  logic [6:0] outs;
  assign outs = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, mc_start, mc_err};

  logic       s_ex_valid, s_jump, s_mc_req;
  logic       s_pc_hold, s_if_id_hold, s_if_id_flush, s_id_ex_hold, s_id_ex_flush, s_start, s_err;
  logic [1:0] s_state;
  logic [15:0] s_stall;
  logic [6:0] s_outs;
  assign s_outs = {s_pc_hold, s_if_id_hold, s_if_id_flush, s_id_ex_hold, s_id_ex_flush, s_start, s_err};

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.FLUSH_CYCLES(3), .MC_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_ex_reg_valid_i(ex_valid), .id_ex_reg_rd_i(rd), .id_ex_reg_mem_rd_i(mem_rd),
    .ex_jump_i(jump), .ex_mc_req_i(mc_req), .mc_done_i(mc_done),
    .hz_pc_hold_o(pc_hold), .hz_if_id_hold_o(if_id_hold), .hz_if_id_flush_o(if_id_flush),
    .hz_id_ex_hold_o(id_ex_hold), .hz_id_ex_flush_o(id_ex_flush),
    .hz_mc_start_o(mc_start), .hz_mc_err_o(mc_err),
    .hz_state_o(state), .hz_stall_cnt_o(stall)
  );

  hazard_ctrl #(.FLUSH_CYCLES(1), .MC_TIMEOUT(65535)) dut_sat (
    .clk(clk), .rst(rst),
    .id_valid_i(1'b0), .id_rs1_i(5'd0), .id_rs2_i(5'd0),
    .id_rs1_used_i(1'b0), .id_rs2_used_i(1'b0),
    .id_ex_reg_valid_i(s_ex_valid), .id_ex_reg_rd_i(5'd0), .id_ex_reg_mem_rd_i(1'b0),
    .ex_jump_i(s_jump), .ex_mc_req_i(s_mc_req), .mc_done_i(1'b0),
    .hz_pc_hold_o(s_pc_hold), .hz_if_id_hold_o(s_if_id_hold), .hz_if_id_flush_o(s_if_id_flush),
    .hz_id_ex_hold_o(s_id_ex_hold), .hz_id_ex_flush_o(s_id_ex_flush),
    .hz_mc_start_o(s_start), .hz_mc_err_o(s_err),
    .hz_state_o(s_state), .hz_stall_cnt_o(s_stall)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_valid = 0; rs1_used = 0; rs2_used = 0; ex_valid = 0; mem_rd = 0;
    jump = 0; mc_req = 0; mc_done = 0; rs1 = 0; rs2 = 0; rd = 0;
    s_ex_valid = 0; s_jump = 0; s_mc_req = 0;
  endtask

  task automatic test_reset;
    rst = 1; idle(); jump = 1; ex_valid = 1; s_jump = 1; s_ex_valid = 1;
    #2;
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL rst_forced outs=%b exp=%b", outs, 7'b0); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got=%b exp=00", state); end
    tick();
    rst = 0; idle(); #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state_after got=%b exp=00", state); end
    checks++; if (stall !== 16'd0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", stall); end
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL rst_idle outs=%b exp=%b", outs, 7'b0); end
  endtask

  task automatic test_load_use;
    ex_valid = 1; mem_rd = 1; rd = 5; id_valid = 1; rs1 = 5; rs1_used = 1; #1;
    checks++; if (outs !== 7'b1100100) begin errors++; $display("FAIL lu_rs1 outs=%b exp=%b", outs, 7'b1100100); end
    tick(); idle(); #1;
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL lu_release outs=%b exp=%b", outs, 7'b0); end
    checks++; if (stall !== 16'd1) begin errors++; $display("FAIL lu_stall got=%0d exp=1", stall); end
    ex_valid = 1; mem_rd = 1; rd = 0; id_valid = 1; rs1 = 0; rs1_used = 1; #1;
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL lu_rd0 outs=%b exp=%b", outs, 7'b0); end
    rd = 5; rs1 = 5; rs1_used = 0; #1;
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL lu_unused outs=%b exp=%b", outs, 7'b0); end
    mem_rd = 0; rs1_used = 1; #1;
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL lu_not_load outs=%b exp=%b", outs, 7'b0); end
    mem_rd = 1; rs1_used = 0; rd = 7; rs2 = 7; rs2_used = 1; #1;
    checks++; if (outs !== 7'b1100100) begin errors++; $display("FAIL lu_rs2 outs=%b exp=%b", outs, 7'b1100100); end
    tick(); idle(); #1;
    checks++; if (stall !== 16'd2) begin errors++; $display("FAIL lu_stall2 got=%0d exp=2", stall); end
  endtask

  task automatic test_multicycle;
    mc_done = 1; #1;
    checks++; if (outs !== 7'b0 || state !== 2'b00) begin errors++; $display("FAIL mc_done_in_run outs=%b state=%b exp=0000000/00", outs, state); end
    tick(); idle();
    ex_valid = 1; mc_req = 1; #1;
    checks++; if (outs !== 7'b1101010) begin errors++; $display("FAIL mc_start outs=%b exp=%b", outs, 7'b1101010); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (outs !== 7'b1101000 || state !== 2'b01) begin errors++; $display("FAIL mc_wait%0d outs=%b state=%b exp=1101000/01", c, outs, state); end
      tick();
    end
    mc_done = 1; #1;
    checks++; if (outs !== 7'b0 || state !== 2'b01) begin errors++; $display("FAIL mc_done outs=%b state=%b exp=0000000/01", outs, state); end
    tick(); idle(); #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL mc_back_run got=%b exp=00", state); end
    checks++; if (stall !== 16'd6) begin errors++; $display("FAIL mc_stall got=%0d exp=6", stall); end
  endtask

  task automatic test_timeout;
    int errs_seen;
    errs_seen = 0;
    ex_valid = 1; mc_req = 1; #1;
    if (mc_err) errs_seen++;
    tick();
    for (int c = 1; c <= 7; c++) begin
      #1;
      if (mc_err) errs_seen++;
      checks++; if (outs !== 7'b1101000) begin errors++; $display("FAIL tmo_wait%0d outs=%b exp=1101000", c, outs); end
      tick();
    end
    #1;
    if (mc_err) errs_seen++;
    checks++; if (outs !== 7'b0000001 || state !== 2'b01) begin errors++; $display("FAIL tmo_fire outs=%b state=%b exp=0000001/01", outs, state); end
    tick(); idle(); #1;
    if (mc_err) errs_seen++;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL tmo_back_run got=%b exp=00", state); end
    checks++; if (errs_seen != 1) begin errors++; $display("FAIL tmo_pulses got=%0d exp=1", errs_seen); end
    checks++; if (stall !== 16'd14) begin errors++; $display("FAIL tmo_stall got=%0d exp=14", stall); end
    ex_valid = 1; mc_req = 1; #1;
    tick();
    for (int c = 1; c <= 7; c++) tick();
    mc_done = 1; #1;
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL tmo_done_wins outs=%b exp=%b", outs, 7'b0); end
    tick(); idle(); #1;
    checks++; if (state !== 2'b00 || stall !== 16'd22) begin errors++; $display("FAIL tmo_done_after state=%b stall=%0d exp=00/22", state, stall); end
  endtask

  task automatic test_redirect;
    jump = 1; ex_valid = 1; mc_req = 1; mem_rd = 1; rd = 5; id_valid = 1; rs1 = 5; rs1_used = 1; mc_done = 1;
    #1;
    checks++; if (outs !== 7'b0010100 || state !== 2'b00) begin errors++; $display("FAIL rd_cycle0 outs=%b state=%b exp=0010100/00", outs, state); end
    tick();
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++; if (outs !== 7'b0010100 || state !== 2'b10) begin errors++; $display("FAIL rd_cycle%0d outs=%b state=%b exp=0010100/10", c, outs, state); end
      tick();
    end
    idle(); #1;
    checks++; if (outs !== 7'b0 || state !== 2'b00) begin errors++; $display("FAIL rd_cycle3 outs=%b state=%b exp=0000000/00", outs, state); end
    checks++; if (stall !== 16'd22) begin errors++; $display("FAIL rd_stall got=%0d exp=22", stall); end
    s_jump = 1; s_ex_valid = 1; #1;
    checks++; if (s_outs !== 7'b0010100) begin errors++; $display("FAIL rd1_flush outs=%b exp=0010100", s_outs); end
    tick(); idle(); #1;
    checks++; if (s_state !== 2'b00 || s_outs !== 7'b0) begin errors++; $display("FAIL rd1_run state=%b outs=%b exp=00/0000000", s_state, s_outs); end
  endtask

  task automatic test_reset_mid;
    ex_valid = 1; mc_req = 1; #1;
    tick(); #1;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL rm_in_wait got=%b exp=01", state); end
    rst = 1; #1;
    checks++; if (outs !== 7'b0 || state !== 2'b00) begin errors++; $display("FAIL rm_wait_forced outs=%b state=%b exp=0000000/00", outs, state); end
    tick(); rst = 0; idle(); #1;
    checks++; if (outs !== 7'b0 || state !== 2'b00 || stall !== 16'd0) begin errors++; $display("FAIL rm_wait_after outs=%b state=%b stall=%0d exp=0000000/00/0", outs, state, stall); end
    jump = 1; ex_valid = 1; #1;
    tick(); idle(); #1;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL rm_in_flush got=%b exp=10", state); end
    rst = 1; #1;
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL rm_flush_forced outs=%b exp=0000000", outs); end
    tick(); rst = 0; #1;
    checks++; if (outs !== 7'b0 || state !== 2'b00 || stall !== 16'd0) begin errors++; $display("FAIL rm_flush_after outs=%b state=%b stall=%0d exp=0000000/00/0", outs, state, stall); end
  endtask

  task automatic test_saturation;
    s_ex_valid = 1; s_mc_req = 1;
    for (int c = 0; c < 65000; c++) tick();
    checks++; if (s_stall !== 16'd65000) begin errors++; $display("FAIL sat_mid got=%0d exp=65000", s_stall); end
    for (int c = 0; c < 5000; c++) tick();
    checks++; if (s_stall !== 16'hFFFF) begin errors++; $display("FAIL sat_end got=%h exp=ffff", s_stall); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_multicycle();
    test_timeout();
    test_redirect();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
